// File: rtl/ext_pkg.sv
// Shared constants for the immediate-extension pipeline: op width and op encodings.
package ext_pkg;

    localparam int EXT_OP_W = 3;

    localparam logic [EXT_OP_W-1:0] EXT_ZERO   = 3'b000;
    localparam logic [EXT_OP_W-1:0] EXT_SIGN   = 3'b001;
    localparam logic [EXT_OP_W-1:0] EXT_UPPER  = 3'b010;
    localparam logic [EXT_OP_W-1:0] EXT_BRANCH = 3'b011;
    localparam logic [EXT_OP_W-1:0] EXT_JUMP   = 3'b100;

endpackage

// File: rtl/ext_pipe_stage.sv
// One valid/ready register slice. Holds its word while stalled; accepts when empty
// or when the downstream slice takes the current word in the same cycle.
module ext_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: extends imm_in per ext_op, flags illegal ops,
// counts them (saturating) at accept time, and carries {illegal,tag,data} through STAGES slices.
module imm_ext_pipe
    import ext_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [EXT_OP_W-1:0] ext_op,
    input  logic [IN_W-1:0]     imm_in,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    imm_out,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_illegal,
    output logic [CNT_W-1:0]    illegal_cnt
);

    localparam int W = 1 + TAG_W + OUT_W;

    function automatic logic [OUT_W-1:0] extend(input logic [EXT_OP_W-1:0] op,
                                                input logic [IN_W-1:0]     imm);
        logic [OUT_W-1:0] z;
        logic [OUT_W-1:0] s;
        z = OUT_W'(imm);
        s = OUT_W'($signed(imm));
        case (op)
            EXT_ZERO:   return z;
            EXT_SIGN:   return s;
            EXT_UPPER:  return {imm, {(OUT_W-IN_W){1'b0}}};
            EXT_BRANCH: return s << 2;
            EXT_JUMP:   return z << 2;
            default:    return '0;
        endcase
    endfunction

    logic illegal;
    assign illegal = (ext_op > EXT_JUMP);

    // Handshake: a word moves across any boundary on a cycle where valid && ready are both
    // high; valid never depends on ready, and ready ripples combinationally from out_ready.
    logic         vld [0:STAGES];
    logic         rdy [0:STAGES];
    logic [W-1:0] dat [0:STAGES];

    assign vld[0]      = in_valid;
    assign dat[0]      = {illegal, in_tag, extend(ext_op, imm_in)};
    assign in_ready    = rdy[0];
    assign rdy[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        ext_pipe_stage #(.W(W)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (vld[k]),
            .in_ready  (rdy[k]),
            .in_data   (dat[k]),
            .out_valid (vld[k+1]),
            .out_ready (rdy[k+1]),
            .out_data  (dat[k+1])
        );
    end

    assign out_valid                      = vld[STAGES];
    assign {out_illegal, out_tag, imm_out} = dat[STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (in_valid && in_ready && illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    if (OUT_W < IN_W + 2) begin : g_bad_width
        $error("imm_ext_pipe: OUT_W must be at least IN_W+2");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("imm_ext_pipe: STAGES must be within 1..4");
    end

endmodule
